// File: rtl/mem_access_unit_pkg.sv
// Shared widths, memory opcodes and decode helpers for the MEM-stage access unit.
package mem_access_unit_pkg;

  localparam int unsigned REGS_ADDR_W = 5;
  localparam int unsigned REGS_DATA_W = 32;
  localparam int unsigned MEM_OP_W    = 3;

  typedef logic [MEM_OP_W-1:0] mem_op_t;

  localparam mem_op_t MEM_OP_NOP = 3'd0;
  localparam mem_op_t MEM_OP_LW  = 3'd1;
  localparam mem_op_t MEM_OP_LB  = 3'd2;
  localparam mem_op_t MEM_OP_LBU = 3'd3;
  localparam mem_op_t MEM_OP_SW  = 3'd4;
  localparam mem_op_t MEM_OP_SB  = 3'd5;

  // Codes 6 and 7 decode as NOP.
  function automatic logic is_mem_op(mem_op_t op);
    case (op)
      MEM_OP_LW, MEM_OP_LB, MEM_OP_LBU, MEM_OP_SW, MEM_OP_SB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(mem_op_t op);
    return (op == MEM_OP_LW) || (op == MEM_OP_LB) || (op == MEM_OP_LBU);
  endfunction

  function automatic logic is_store(mem_op_t op);
    return (op == MEM_OP_SW) || (op == MEM_OP_SB);
  endfunction

  function automatic logic is_word_op(mem_op_t op);
    return (op == MEM_OP_LW) || (op == MEM_OP_SW);
  endfunction

  // Big-endian lanes: offset 0 is bits 31:24.
  function automatic logic [3:0] byte_sel(mem_op_t op, logic [1:0] off);
    if (is_word_op(op)) return 4'b1111;
    case (off)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_formatter.sv
// Combinational load-data formatter: big-endian byte select plus sign/zero extension.
module mem_load_formatter
  import mem_access_unit_pkg::*;
(
  input  mem_op_t     i_op,
  input  logic [1:0]  i_byte_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0] w_byte;

  always_comb begin
    case (i_byte_off)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  always_comb begin
    o_data = i_rdata;
    case (i_op)
      MEM_OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEM_OP_LBU: o_data = {24'h000000, w_byte};
      default:    o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit over a req/ack bus; stalls upstream while a transaction is open.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned LW/SW in IDLE with align_error.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TIMER_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_write_enable,
  input  logic [REGS_ADDR_W-1:0] mem_write_addr,
  input  logic [REGS_DATA_W-1:0] mem_write_data,
  input  mem_op_t                mem_op,
  input  logic [31:0]            mem_addr,
  input  logic [REGS_DATA_W-1:0] mem_store_data,
  output logic                   wb_write_enable,
  output logic [REGS_ADDR_W-1:0] wb_write_addr,
  output logic [REGS_DATA_W-1:0] wb_write_data,
  output logic                   stall_request,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [31:0]            bus_addr,
  output logic [3:0]             bus_byte_sel,
  output logic [31:0]            bus_wdata,
  input  logic                   bus_ack,
  input  logic [31:0]            bus_rdata,
  output logic                   bus_error,
  output logic                   align_error
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBus  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [TIMER_WIDTH-1:0] TimeoutLast = TIMER_WIDTH'(ACK_TIMEOUT - 1);

  logic [1:0]             r_state;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [31:0]            r_load_data;
  mem_op_t                r_op;
  logic [1:0]             r_byte_off;
  logic                   r_aborted;

  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_start;
  logic        w_timeout;
  logic [31:0] w_fmt_data;

  assign w_is_mem = is_mem_op(mem_op);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = is_word_op(mem_op) && (mem_addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_start   = (r_state == StIdle) && w_is_mem && !w_misaligned;
  assign w_timeout = (ACK_TIMEOUT != 0) && (r_timer == TimeoutLast) && !bus_ack;

  // Op and offset are latched so formatting does not rely on the held EX/MEM inputs.
  mem_load_formatter u_load_formatter (
    .i_op       (r_op),
    .i_byte_off (r_byte_off),
    .i_rdata    (bus_rdata),
    .o_data     (w_fmt_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StIdle;
      r_timer      <= '0;
      r_load_data  <= '0;
      r_op         <= MEM_OP_NOP;
      r_byte_off   <= 2'b00;
      r_aborted    <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_byte_sel <= '0;
      bus_wdata    <= '0;
      bus_error    <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            bus_req      <= 1'b1;
            bus_we       <= is_store(mem_op);
            bus_addr     <= {mem_addr[31:2], 2'b00};
            bus_byte_sel <= byte_sel(mem_op, mem_addr[1:0]);
            bus_wdata    <= (mem_op == MEM_OP_SB) ? {4{mem_store_data[7:0]}} : mem_store_data;
            r_op         <= mem_op;
            r_byte_off   <= mem_addr[1:0];
            r_timer      <= '0;
            r_aborted    <= 1'b0;
            r_state      <= StBus;
          end
        end
        StBus: begin
          r_timer <= r_timer + 1'b1;
          if (bus_ack) begin
            bus_req     <= 1'b0;
            r_load_data <= w_fmt_data;
            r_state     <= StDone;
          end else if (w_timeout) begin
            bus_req   <= 1'b0;
            bus_error <= 1'b1;
            r_aborted <= 1'b1;
            r_state   <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    stall_request   = 1'b0;
    wb_write_enable = 1'b0;
    wb_write_addr   = mem_write_addr;
    wb_write_data   = mem_write_data;
    align_error     = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_is_mem) begin
          wb_write_enable = mem_write_enable;
        end else if (w_misaligned) begin
          align_error = 1'b1;
        end else begin
          stall_request = 1'b1;
        end
      end
      StBus: stall_request = 1'b1;
      StDone: begin
        wb_write_enable = mem_write_enable && !r_aborted;
        if (is_load(r_op)) wb_write_data = r_load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scoreboard of expected writebacks, immediate assertions.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clock;
  logic        reset;
  logic        mem_write_enable;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_write_data;
  mem_op_t     mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic        wb_write_enable;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic        stall_request;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byte_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_error;
  logic        align_error;

  mem_access_unit #(
    .ACK_TIMEOUT (4),
    .TIMER_WIDTH (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .mem_write_enable (mem_write_enable),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data),
    .mem_op           (mem_op),
    .mem_addr         (mem_addr),
    .mem_store_data   (mem_store_data),
    .wb_write_enable  (wb_write_enable),
    .wb_write_addr    (wb_write_addr),
    .wb_write_data    (wb_write_data),
    .stall_request    (stall_request),
    .bus_req          (bus_req),
    .bus_we           (bus_we),
    .bus_addr         (bus_addr),
    .bus_byte_sel     (bus_byte_sel),
    .bus_wdata        (bus_wdata),
    .bus_ack          (bus_ack),
    .bus_rdata        (bus_rdata),
    .bus_error        (bus_error),
    .align_error      (align_error)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_sel;
  logic        cap_we;
  int          stalls;
  int          req_cycles;
  int          err_in_bus;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input mem_op_t op, input logic we, input logic [4:0] waddr,
                       input logic [31:0] wdata, input logic [31:0] addr,
                       input logic [31:0] sdata);
    mem_op           = op;
    mem_write_enable = we;
    mem_write_addr   = waddr;
    mem_write_data   = wdata;
    mem_addr         = addr;
    mem_store_data   = sdata;
    #1;
  endtask

  task automatic check_wb(input string tag);
    wb_exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_we"}, 32'(wb_write_enable), 32'(e.we));
      check({tag, "_addr"}, 32'(wb_write_addr), 32'(e.addr));
      if (e.we) check({tag, "_data"}, wb_write_data, e.data);
    end
  endtask

  // Runs until stall drops (or a cycle budget expires); ack_at = 0 means never ack.
  task automatic run_txn(input string tag, input int ack_at, input logic [31:0] rdata);
    stalls     = 0;
    req_cycles = 0;
    err_in_bus = 0;
    for (int i = 0; i < 40 && stall_request; i++) begin
      stalls++;
      if (bus_error) err_in_bus++;
      if (bus_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          cap_addr  = bus_addr;
          cap_wdata = bus_wdata;
          cap_sel   = bus_byte_sel;
          cap_we    = bus_we;
        end
        if (req_cycles == ack_at) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
        end
      end
      tick();
      bus_ack = 1'b0;
    end
    check({tag, "_bounded"}, 32'(stall_request), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    drive(MEM_OP_NOP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_sel", 32'(bus_byte_sel), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_stall", 32'(stall_request), 32'd0);
    reset = 1'b0;
    tick();

    // NOP passes through in zero cycles
    drive(MEM_OP_NOP, 1'b1, 5'd5, 32'h00001234, 32'h0, 32'h0);
    sb.push_back('{1'b1, 5'd5, 32'h00001234});
    check_wb("nop");
    check("nop_stall", 32'(stall_request), 32'd0);
    check("nop_bus_req", 32'(bus_req), 32'd0);
    check("nop_align", 32'(align_error), 32'd0);
    tick();

    // Opcode 7 behaves as NOP
    drive(3'd7, 1'b1, 5'd9, 32'h0000CAFE, 32'h40, 32'h0);
    sb.push_back('{1'b1, 5'd9, 32'h0000CAFE});
    check_wb("op7");
    check("op7_stall", 32'(stall_request), 32'd0);
    tick();
    check("op7_no_req", 32'(bus_req), 32'd0);

    // LW, ack on the second bus cycle
    drive(MEM_OP_LW, 1'b1, 5'd7, 32'h00005555, 32'h100, 32'h0);
    sb.push_back('{1'b1, 5'd7, 32'hDEADBEEF});
    run_txn("lw", 2, 32'hDEADBEEF);
    check("lw_stalls", 32'(stalls), 32'd3);
    check("lw_req_cycles", 32'(req_cycles), 32'd2);
    check("lw_addr", cap_addr, 32'h100);
    check("lw_sel", 32'(cap_sel), 32'hF);
    check("lw_we", 32'(cap_we), 32'd0);
    check_wb("lw");
    drive(MEM_OP_NOP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();

    // LB sign-extends the lane at offset 3
    drive(MEM_OP_LB, 1'b1, 5'd8, 32'h0, 32'h103, 32'h0);
    sb.push_back('{1'b1, 5'd8, 32'hFFFFFF80});
    run_txn("lb", 1, 32'h11223380);
    check("lb_stalls", 32'(stalls), 32'd2);
    check("lb_sel", 32'(cap_sel), 32'h1);
    check("lb_addr", cap_addr, 32'h100);
    check_wb("lb");
    drive(MEM_OP_NOP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();

    drive(MEM_OP_LBU, 1'b1, 5'd10, 32'h0, 32'h103, 32'h0);
    sb.push_back('{1'b1, 5'd10, 32'h00000080});
    run_txn("lbu", 3, 32'h11223380);
    check("lbu_stalls", 32'(stalls), 32'd4);
    check_wb("lbu");
    drive(MEM_OP_NOP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();

    // SB replicates the byte and selects lane 2; writeback carries the ALU value
    drive(MEM_OP_SB, 1'b1, 5'd3, 32'h00000077, 32'h102, 32'h000000AB);
    sb.push_back('{1'b1, 5'd3, 32'h00000077});
    run_txn("sb", 1, 32'h0);
    check("sb_we", 32'(cap_we), 32'd1);
    check("sb_sel", 32'(cap_sel), 32'h2);
    check("sb_wdata", cap_wdata, 32'hABABABAB);
    check("sb_addr", cap_addr, 32'h100);
    check_wb("sb");
    drive(MEM_OP_NOP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();

    // Misaligned word access
`ifdef MEM_ALIGN_CHECK_EN
    drive(MEM_OP_LW, 1'b1, 5'd4, 32'h00000099, 32'h102, 32'h0);
    check("mis_align", 32'(align_error), 32'd1);
    check("mis_stall", 32'(stall_request), 32'd0);
    check("mis_wb_we", 32'(wb_write_enable), 32'd0);
    drive(MEM_OP_NOP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    check("mis_no_req", 32'(bus_req), 32'd0);
`else
    drive(MEM_OP_SW, 1'b1, 5'd4, 32'h00000099, 32'h102, 32'h12345678);
    check("mis_align", 32'(align_error), 32'd0);
    sb.push_back('{1'b1, 5'd4, 32'h00000099});
    run_txn("mis", 1, 32'h0);
    check("mis_addr", cap_addr, 32'h100);
    check("mis_sel", 32'(cap_sel), 32'hF);
    check("mis_wdata", cap_wdata, 32'h12345678);
    check_wb("mis");
    drive(MEM_OP_NOP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
`endif

    // Timeout after 4 bus cycles without ack
    drive(MEM_OP_LW, 1'b1, 5'd6, 32'h00000001, 32'h200, 32'h0);
    sb.push_back('{1'b0, 5'd6, 32'h0});
    run_txn("tmo", 0, 32'h0);
    check("tmo_stalls", 32'(stalls), 32'd5);
    check("tmo_req_cycles", 32'(req_cycles), 32'd4);
    check("tmo_err_in_bus", 32'(err_in_bus), 32'd0);
    check("tmo_err_done", 32'(bus_error), 32'd1);
    check_wb("tmo");
    drive(MEM_OP_NOP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    check("tmo_err_clear", 32'(bus_error), 32'd0);
    check("tmo_idle_stall", 32'(stall_request), 32'd0);
    check("tmo_idle_req", 32'(bus_req), 32'd0);

    // Reset while BUS, then a late ack
    drive(MEM_OP_LW, 1'b1, 5'd2, 32'h0, 32'h300, 32'h0);
    tick();
    check("rbus_req", 32'(bus_req), 32'd1);
    reset = 1'b1;
    drive(MEM_OP_NOP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    check("rbus_req_clr", 32'(bus_req), 32'd0);
    check("rbus_stall", 32'(stall_request), 32'd0);
    check("rbus_addr_clr", bus_addr, 32'h0);
    reset     = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hBADBAD00;
    tick();
    bus_ack = 1'b0;
    check("late_ack_req", 32'(bus_req), 32'd0);
    check("late_ack_stall", 32'(stall_request), 32'd0);
    check("late_ack_err", 32'(bus_error), 32'd0);
    check("late_ack_wb_we", 32'(wb_write_enable), 32'd0);
    drive(MEM_OP_NOP, 1'b1, 5'd1, 32'h00000042, 32'h0, 32'h0);
    sb.push_back('{1'b1, 5'd1, 32'h00000042});
    check_wb("post_rst");
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
